// File: rtl/pc_seq_pkg.sv
// Shared constants and next-PC source encoding for the PC sequencer slice.
package pc_seq_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_RAS_DEPTH   = 4;
    localparam int DEF_RESET_PC    = 0;
    localparam int DEF_INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        SEQ,
        BRANCH,
        JUMP,
        CALL,
        RET
    } next_src_e;

    // Fixed priority ret > call > jump > branch > sequential.
    function automatic next_src_e select_src(input logic branch, input logic jump,
                                             input logic call, input logic ret);
        if (ret)         return RET;
        else if (call)   return CALL;
        else if (jump)   return JUMP;
        else if (branch) return BRANCH;
        else             return SEQ;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, sticky ovf/udf flags.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;

    // ptr is the next free slot; once full it also points at the oldest entry.
    assign top   = ptr - PTR_W'(1);
    assign data  = mem[top];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (push) begin
                ptr <= ptr + PTR_W'(1);
                if (!full) count <= count + CNT_W'(1);
            end else if (pop && !empty) begin
                ptr   <= top;
                count <= count - CNT_W'(1);
            end

            if (push && full)  ovf <= 1'b1;
            else if (err_clr)  ovf <= 1'b0;

            if (pop && empty)  udf <= 1'b1;
            else if (err_clr)  udf <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch/jump/call/ret; the return-address stack
// is built only when PC_SEQ_RAS_EN is defined (otherwise call/ret act as jumps).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               RAS_DEPTH   = DEF_RAS_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEF_RESET_PC),
    parameter int               INSTR_BYTES = DEF_INSTR_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_udf,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

    next_src_e        src;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ret_pc;
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] next_pc;
    logic             next_misalign;

    assign src    = select_src(branch, jump, call, ret);
    assign seq_pc = pc + STEP;

`ifdef PC_SEQ_RAS_EN
    logic [WIDTH-1:0] ras_data;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (!stall && (src == CALL)),
        .pop       (!stall && (src == RET)),
        .err_clr   (err_clr && !stall),
        .push_data (seq_pc),
        .data      (ras_data),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .udf       (ras_udf)
    );

    // Underflow restarts execution from the reset vector.
    assign ret_pc = ras_empty ? RESET_PC : ras_data;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ret_pc         = target;
    assign ras_empty      = 1'b1;
    assign ras_full       = 1'b0;
    assign ras_ovf        = 1'b0;
    assign ras_udf        = 1'b0;
`endif

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        raw_next = seq_pc;
        case (src)
            BRANCH:     raw_next = seq_pc + offset;
            JUMP, CALL: raw_next = target;
            RET:        raw_next = ret_pc;
            default:    raw_next = seq_pc;
        endcase
    end

    assign next_pc       = raw_next & ~ALIGN_MASK;
    assign next_misalign = |(raw_next & ALIGN_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else if (!stall) begin
            pc       <= next_pc;
            misalign <= next_misalign;
        end
    end

endmodule
